// File: rtl/mod_acc_ctrl_if.sv
// mod_acc_ctrl_if: job request and accumulator-control bundle for mod_acc_ctrl.
//   master : job requester. Drives iValid/iData/iMod/iLen and observes everything else.
//   slave  : mod_acc_ctrl. Accepts the job and drives the operands, controls and status.
// Signals:
//   iValid / oReady          job handshake
//   iData, iMod, iLen        job fields, sampled on accept
//   oData, oMod              operands to the accumulator
//   oClr, oEn                accumulator clear/enable
//   oRemain                  enable cycles still to issue
//   oBusy, oDone, oErr       status
interface mod_acc_ctrl_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned LENWIDTH = 16
);
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iData;
  logic [BITWIDTH-1:0] iMod;
  logic [LENWIDTH-1:0] iLen;
  logic [BITWIDTH-1:0] oData;
  logic [BITWIDTH-1:0] oMod;
  logic                oClr;
  logic                oEn;
  logic [LENWIDTH-1:0] oRemain;
  logic                oBusy;
  logic                oDone;
  logic                oErr;

  modport master (
    output iValid, iData, iMod, iLen,
    input  oReady, oData, oMod, oClr, oEn, oRemain, oBusy, oDone, oErr
  );

  modport slave (
    input  iValid, iData, iMod, iLen,
    output oReady, oData, oMod, oClr, oEn, oRemain, oBusy, oDone, oErr
  );
endinterface

// File: rtl/mod_acc_ctrl.sv
// mod_acc_ctrl: job sequencer in front of mod_accumulator.
// Accepts {data, mod, len}, validates it, then issues one clear cycle followed by exactly
// len enable cycles, and pulses oDone. Bad jobs (mod==0) pulse oErr and are dropped.
// Optional feature macro: MOD_ACC_CTRL_REDUCE_EN
//   defined   : data >= mod is reduced by repeated subtraction (REDUCE state) before CLEAR.
//   undefined : data >= mod is rejected with an oErr pulse.
// Ports:
//   iClk  clock, rising edge
//   iRst  synchronous active-high reset
//   bus   mod_acc_ctrl_if.slave (job handshake, accumulator operands/controls, status)
module mod_acc_ctrl #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned LENWIDTH = 16
) (
  input logic           iClk,
  input logic           iRst,
  mod_acc_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
`ifdef MOD_ACC_CTRL_REDUCE_EN
  localparam logic [2:0] REDUCE = 3'd1;
`endif

  logic [2:0]          r_state, w_state_d;
  logic [BITWIDTH-1:0] r_data,  w_data_d;
  logic [BITWIDTH-1:0] r_mod,   w_mod_d;
  logic [LENWIDTH-1:0] r_remain, w_remain_d;
  logic                r_err,   w_err_d;
  logic                w_accept;

`ifdef MOD_ACC_CTRL_REDUCE_EN
  logic [BITWIDTH-1:0] w_diff;
  assign w_diff = r_data - r_mod;
`endif

  assign bus.oReady = (r_state == IDLE) && !iRst;
  assign w_accept   = bus.iValid && bus.oReady;

  always_comb begin
    w_state_d  = r_state;
    w_data_d   = r_data;
    w_mod_d    = r_mod;
    w_remain_d = r_remain;
    w_err_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.iMod == '0) begin
            // Rejected: operands keep the previous job's values.
            w_err_d = 1'b1;
          end else if (bus.iLen == '0) begin
            w_state_d = DONE;
            w_data_d  = bus.iData;
            w_mod_d   = bus.iMod;
          end else if (bus.iData >= bus.iMod) begin
`ifdef MOD_ACC_CTRL_REDUCE_EN
            w_state_d  = REDUCE;
            w_data_d   = bus.iData;
            w_mod_d    = bus.iMod;
            w_remain_d = bus.iLen;
`else
            w_err_d = 1'b1;
`endif
          end else begin
            w_state_d  = CLEAR;
            w_data_d   = bus.iData;
            w_mod_d    = bus.iMod;
            w_remain_d = bus.iLen;
          end
        end
      end
`ifdef MOD_ACC_CTRL_REDUCE_EN
      REDUCE: begin
        // Entry guarantees data >= mod, so every REDUCE cycle subtracts once; leave as soon
        // as the result drops below mod, giving floor(data/mod) cycles.
        w_data_d = w_diff;
        if (w_diff < r_mod) w_state_d = CLEAR;
      end
`endif
      CLEAR: w_state_d = RUN;
      RUN: begin
        if (r_remain == LENWIDTH'(1)) begin
          w_state_d  = DONE;
          w_remain_d = '0;
        end else begin
          w_remain_d = r_remain - LENWIDTH'(1);
        end
      end
      DONE: begin
        w_state_d  = IDLE;
        w_remain_d = '0;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_mod    <= '0;
      r_remain <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_data   <= w_data_d;
      r_mod    <= w_mod_d;
      r_remain <= w_remain_d;
      r_err    <= w_err_d;
    end
  end

  assign bus.oData   = r_data;
  assign bus.oMod    = r_mod;
  assign bus.oRemain = r_remain;
  assign bus.oClr    = (r_state == CLEAR);
  assign bus.oEn     = (r_state == RUN);
  assign bus.oBusy   = (r_state != IDLE);
  assign bus.oDone   = (r_state == DONE);
  assign bus.oErr    = r_err;

endmodule

// File: tb/tb_mod_acc_ctrl.sv
// tb_mod_acc_ctrl: directed bench for mod_acc_ctrl with a behavioural accumulator model.
// Sample index i in observe() is the i-th sample taken #1 after a rising edge, the first
// edge being the accept edge; so sample 1 shows the state entered at the accept edge.
module tb_mod_acc_ctrl;
  localparam int unsigned BW = 32;
  localparam int unsigned LW = 16;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  mod_acc_ctrl_if #(.BITWIDTH(BW), .LENWIDTH(LW)) bus ();

  mod_acc_ctrl #(.BITWIDTH(BW), .LENWIDTH(LW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  // Reference accumulator: clear to 0, else acc = (acc + data) mod mod when enabled.
  logic [63:0] acc;
  always @(posedge iClk) begin
    if (iRst || bus.oClr) acc <= 64'd0;
    else if (bus.oEn)     acc <= (acc + 64'(bus.oData)) % 64'(bus.oMod);
  end

  int total = 0;
  int bad   = 0;

  int n_clr, n_en, first_clr, first_en, last_en, done_at, done_last, done_cnt;
  int err_at, err_cnt, ready_low, busy_other;
  int remain_clr, remain_first_en, remain_last_en, remain_done, data_at_clr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [BW-1:0] d, input logic [BW-1:0] m, input logic [LW-1:0] l);
    bus.iData  = d;
    bus.iMod   = m;
    bus.iLen   = l;
    bus.iValid = 1'b1;
  endtask

  task automatic observe(input int n, input bit hold);
    n_clr = 0; n_en = 0; first_clr = 0; first_en = 0; last_en = 0;
    done_at = 0; done_last = 0; done_cnt = 0; err_at = 0; err_cnt = 0;
    ready_low = 0; busy_other = 0; remain_clr = -1; remain_first_en = -1;
    remain_last_en = -1; remain_done = -1; data_at_clr = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge iClk);
      #1;
      if (!hold) bus.iValid = 1'b0;
      if (bus.oClr) begin
        n_clr++;
        if (first_clr == 0) begin
          first_clr   = i;
          remain_clr  = int'(bus.oRemain);
          data_at_clr = int'(bus.oData);
        end
      end
      if (bus.oEn) begin
        n_en++;
        if (first_en == 0) begin
          first_en        = i;
          remain_first_en = int'(bus.oRemain);
        end
        last_en        = i;
        remain_last_en = int'(bus.oRemain);
      end
      if (bus.oDone) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
        done_last   = i;
        remain_done = int'(bus.oRemain);
      end
      if (bus.oErr) begin
        err_cnt++;
        if (err_at == 0) err_at = i;
      end
      if (!bus.oReady) ready_low++;
      if (bus.oBusy && !bus.oClr && !bus.oEn && !bus.oDone) busy_other++;
    end
  endtask

  initial begin
    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iMod   = '0;
    bus.iLen   = '0;
    iRst       = 1'b1;

    // 1. reset
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_ready_in_reset", 64'(bus.oReady), 64'd0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    chk("rst_ready",  64'(bus.oReady),  64'd1);
    chk("rst_busy",   64'(bus.oBusy),   64'd0);
    chk("rst_clr",    64'(bus.oClr),    64'd0);
    chk("rst_en",     64'(bus.oEn),     64'd0);
    chk("rst_done",   64'(bus.oDone),   64'd0);
    chk("rst_err",    64'(bus.oErr),    64'd0);
    chk("rst_data",   64'(bus.oData),   64'd0);
    chk("rst_mod",    64'(bus.oMod),    64'd0);
    chk("rst_remain", 64'(bus.oRemain), 64'd0);

    // 2. normal job data=10 mod=13 len=40
    send(10, 13, 40);
    observe(45, 1'b0);
    chk("n_first_clr",   64'(first_clr),       64'd1);
    chk("n_clr_cnt",     64'(n_clr),           64'd1);
    chk("n_remain_clr",  64'(remain_clr),      64'd40);
    chk("n_first_en",    64'(first_en),        64'd2);
    chk("n_en_cnt",      64'(n_en),            64'd40);
    chk("n_last_en",     64'(last_en),         64'd41);
    chk("n_rem_first",   64'(remain_first_en), 64'd40);
    chk("n_rem_last",    64'(remain_last_en),  64'd1);
    chk("n_done_at",     64'(done_at),         64'd42);
    chk("n_done_cnt",    64'(done_cnt),        64'd1);
    chk("n_rem_done",    64'(remain_done),     64'd0);
    chk("n_acc",         acc,                  64'd10);
    chk("n_ready_after", 64'(bus.oReady),      64'd1);
    chk("n_data_hold",   64'(bus.oData),       64'd10);
    chk("n_mod_hold",    64'(bus.oMod),        64'd13);

    // 3. mod=0 rejected
    send(5, 0, 8);
    observe(4, 1'b0);
    chk("z_err_at",    64'(err_at),    64'd1);
    chk("z_err_cnt",   64'(err_cnt),   64'd1);
    chk("z_clr",       64'(n_clr),     64'd0);
    chk("z_en",        64'(n_en),      64'd0);
    chk("z_ready_low", 64'(ready_low), 64'd0);
    chk("z_data",      64'(bus.oData), 64'd10);
    chk("z_mod",       64'(bus.oMod),  64'd13);

    // 4. data >= mod
    send(30, 13, 4);
    observe(12, 1'b0);
`ifdef MOD_ACC_CTRL_REDUCE_EN
    chk("r_reduce_cyc", 64'(busy_other),  64'd2);
    chk("r_first_clr",  64'(first_clr),   64'd3);
    chk("r_data_clr",   64'(data_at_clr), 64'd4);
    chk("r_en_cnt",     64'(n_en),        64'd4);
    chk("r_done_at",    64'(done_at),     64'd8);
    chk("r_err_cnt",    64'(err_cnt),     64'd0);
`else
    chk("r_err_at",  64'(err_at),    64'd1);
    chk("r_clr",     64'(n_clr),     64'd0);
    chk("r_en",      64'(n_en),      64'd0);
    chk("r_done",    64'(done_cnt),  64'd0);
    chk("r_data",    64'(bus.oData), 64'd10);
`endif

    // 5. len=0 with iValid held: back-to-back accepts
    send(3, 7, 0);
    observe(4, 1'b1);
    bus.iValid = 1'b0;
    chk("l0_done_at",   64'(done_at),   64'd1);
    chk("l0_done_last", 64'(done_last), 64'd3);
    chk("l0_done_cnt",  64'(done_cnt),  64'd2);
    chk("l0_clr",       64'(n_clr),     64'd0);
    chk("l0_en",        64'(n_en),      64'd0);
    chk("l0_ready_low", 64'(ready_low), 64'd2);
    chk("l0_data",      64'(bus.oData), 64'd3);
    chk("l0_mod",       64'(bus.oMod),  64'd7);
    @(posedge iClk);
    #1;

    // 6. reset during RUN cycle 5 of len=20
    send(1, 7, 20);
    observe(6, 1'b0);
    chk("x_first_en", 64'(first_en), 64'd2);
    chk("x_en_cnt",   64'(n_en),     64'd5);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    chk("x_en",    64'(bus.oEn),    64'd0);
    chk("x_clr",   64'(bus.oClr),   64'd0);
    chk("x_busy",  64'(bus.oBusy),  64'd0);
    chk("x_ready", 64'(bus.oReady), 64'd0);
    iRst = 1'b0;
    observe(3, 1'b0);
    chk("x_no_done",   64'(done_cnt),  64'd0);
    chk("x_no_en",     64'(n_en),      64'd0);
    chk("x_ready_low", 64'(ready_low), 64'd0);
    send(1, 7, 20);
    observe(25, 1'b0);
    chk("x2_en_cnt",  64'(n_en),     64'd20);
    chk("x2_first_en", 64'(first_en), 64'd2);
    chk("x2_done_at", 64'(done_at),  64'd22);
    chk("x2_acc",     acc,           64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
